// File: rtl/sort_frame_loader.sv
// Front-end loader for the 4-input sorting network: gathers up to four words
// per frame, pads short frames with all-ones, and holds the sorted result
// until the consumer takes it.
module sort_frame_loader #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [WIDTH-1:0]   net_d1,
  output logic [WIDTH-1:0]   net_d2,
  output logic [WIDTH-1:0]   net_d3,
  output logic [WIDTH-1:0]   net_d4,
  input  logic [4*WIDTH-1:0] net_d,
  output logic [4*WIDTH-1:0] out_data,
  output logic [2:0]         out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  // All-ones pad sorts to the top under unsigned ordering.
  localparam logic [WIDTH-1:0] Pad = '1;

  typedef enum logic [1:0] {StFill, StSort, StHold} stateE;

  stateE            stateQ, stateD;
  logic [WIDTH-1:0] slotQ [4];
  logic [1:0]       idxQ;
  logic [2:0]       countQ;
  logic             accept;
  logic             frameDone;
  logic             holdExit;

  // Next-state and handshake decode; in_ready depends on state only.
  always_comb begin
    stateD    = stateQ;
    in_ready  = 1'b0;
    accept    = 1'b0;
    frameDone = 1'b0;
    holdExit  = 1'b0;
    unique case (stateQ)
      StFill: begin
        in_ready  = 1'b1;
        accept    = in_valid;
        frameDone = in_valid && ((idxQ == 2'd3) || in_last);
        if (frameDone) stateD = StSort;
      end
      StSort: stateD = StHold;
      StHold: begin
        holdExit = out_ready;
        if (out_ready) stateD = StFill;
      end
      default: stateD = StFill;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= StFill;
    else     stateQ <= stateD;
  end

  // Slot, index and count registers; slots return to pad when the frame is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) slotQ[i] <= Pad;
      idxQ   <= 2'd0;
      countQ <= 3'd0;
    end else if (holdExit) begin
      for (int i = 0; i < 4; i++) slotQ[i] <= Pad;
      idxQ   <= 2'd0;
      countQ <= 3'd0;
    end else if (accept) begin
      slotQ[idxQ] <= in_data;
      countQ      <= countQ + 3'd1;
      // Index freezes on the closing word; it is cleared on hold exit.
      if (!frameDone) idxQ <= idxQ + 2'd1;
    end
  end

  // Output register: captured once per frame, held until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_count <= 3'd0;
      out_valid <= 1'b0;
    end else if (stateQ == StSort) begin
      out_data  <= net_d;
      out_count <= countQ;
      out_valid <= 1'b1;
    end else if (holdExit) begin
      out_valid <= 1'b0;
    end
  end

  assign net_d1 = slotQ[0];
  assign net_d2 = slotQ[1];
  assign net_d3 = slotQ[2];
  assign net_d4 = slotQ[3];

endmodule

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader: a behavioural sorting network
// closes the loop, and a frame-level model predicts every output each cycle.
module tb_sort_frame_loader;

  localparam logic [15:0] PAD = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] net_d1, net_d2, net_d3, net_d4;
  logic [63:0] net_d;
  logic [63:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  sort_frame_loader #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .net_d1   (net_d1),
    .net_d2   (net_d2),
    .net_d3   (net_d3),
    .net_d4   (net_d4),
    .net_d    (net_d),
    .out_data (out_data),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Ascending sort of four words, packed {y4,y3,y2,y1}.
  function automatic logic [63:0] sortPack(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [15:0] d);
    logic [15:0] v [4];
    logic [15:0] t;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return {v[3], v[2], v[1], v[0]};
  endfunction

  // Stand-in for the combinational sorting network.
  assign net_d = sortPack(net_d1, net_d2, net_d3, net_d4);

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  // Frame-level model state.
  logic [15:0] frameQ [$];
  logic [15:0] slotsExp [4];
  bit          busy;
  int          closeCycle;
  logic [63:0] expData, lastData;
  logic [2:0]  expCount, lastCount;
  bit          prevOv;
  bit          lastAcc;
  int          riseQ [$];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    frameQ.delete();
    for (int i = 0; i < 4; i++) slotsExp[i] = PAD;
    busy      = 1'b0;
    lastData  = '0;
    lastCount = '0;
    prevOv    = 1'b0;
  endtask

  // Check the current cycle, drive inputs for the next edge, advance one cycle.
  task automatic cycle(input bit v, input logic [15:0] d, input bit l, input bit r);
    bit expValid;
    logic [15:0] w [4];
    expValid = busy && (cyc >= closeCycle + 2);
    if (expValid) begin
      lastData  = expData;
      lastCount = expCount;
    end
    checkVal("in_ready", in_ready, !busy);
    checkVal("out_valid", out_valid, expValid);
    checkVal("out_data", out_data, lastData);
    checkVal("out_count", out_count, lastCount);
    checkVal("slots", {net_d4, net_d3, net_d2, net_d1},
             {slotsExp[3], slotsExp[2], slotsExp[1], slotsExp[0]});
    if (out_valid && !prevOv) riseQ.push_back(cyc);
    prevOv = out_valid;

    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    lastAcc   = v && !busy;
    if (lastAcc) begin
      slotsExp[frameQ.size()] = d;
      frameQ.push_back(d);
      if (frameQ.size() == 4 || l) begin
        for (int i = 0; i < 4; i++) w[i] = (i < frameQ.size()) ? frameQ[i] : PAD;
        expData    = sortPack(w[0], w[1], w[2], w[3]);
        expCount   = 3'(frameQ.size());
        busy       = 1'b1;
        closeCycle = cyc;
        frameQ.delete();
      end
    end else if (expValid && r) begin
      busy = 1'b0;
      for (int i = 0; i < 4; i++) slotsExp[i] = PAD;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  // Asynchronous reset applied mid-cycle, released on a falling edge.
  task automatic resetDut();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkVal("async_rst_out_valid", out_valid, 1'b0);
    checkVal("async_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    modelReset();
  endtask

  logic [15:0] tq [$];
  int          ti;

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkVal("reset_out_count", out_count, 3'd0);
    checkVal("reset_out_data", out_data, 64'h0);
    checkVal("reset_net_d1", net_d1, PAD);
    idle(2);

    // Full frame.
    cycle(1'b1, 16'd5, 1'b0, 1'b1);
    cycle(1'b1, 16'd3, 1'b0, 1'b1);
    cycle(1'b1, 16'd9, 1'b0, 1'b1);
    cycle(1'b1, 16'd1, 1'b0, 1'b1);
    idle(4);
    checkVal("full_data", out_data, 64'h0009_0005_0003_0001);
    checkVal("full_count", out_count, 3'd4);

    // Short frame followed by a clean full frame.
    cycle(1'b1, 16'd7, 1'b0, 1'b1);
    cycle(1'b1, 16'd2, 1'b1, 1'b1);
    idle(4);
    checkVal("short_data", out_data, 64'hFFFF_FFFF_0007_0002);
    checkVal("short_count", out_count, 3'd2);
    cycle(1'b1, 16'd40, 1'b0, 1'b1);
    cycle(1'b1, 16'd10, 1'b0, 1'b1);
    cycle(1'b1, 16'd30, 1'b0, 1'b1);
    cycle(1'b1, 16'd20, 1'b0, 1'b1);
    idle(4);
    checkVal("after_short_data", out_data, 64'h0028_001E_0014_000A);

    // Backpressure with in_valid held high throughout.
    for (int k = 0; k < 16; k++) cycle(1'b1, 16'(100 + k), 1'b0, k >= 10);
    idle(5);

    // Duplicates and extremes.
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b1);
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b1);
    idle(4);
    checkVal("dup_data", out_data, 64'hFFFF_FFFF_0000_0000);
    checkVal("dup_count", out_count, 3'd4);

    // Reset after two accepted words, then a fresh frame.
    cycle(1'b1, 16'd77, 1'b0, 1'b1);
    cycle(1'b1, 16'd66, 1'b0, 1'b1);
    resetDut();
    idle(3);
    cycle(1'b1, 16'd4, 1'b0, 1'b1);
    cycle(1'b1, 16'd8, 1'b0, 1'b1);
    cycle(1'b1, 16'd2, 1'b0, 1'b1);
    cycle(1'b1, 16'd6, 1'b0, 1'b1);
    idle(4);
    checkVal("post_rst_data", out_data, 64'h0008_0006_0004_0002);

    // Reset while holding a result.
    cycle(1'b1, 16'd11, 1'b0, 1'b0);
    cycle(1'b1, 16'd12, 1'b0, 1'b0);
    cycle(1'b1, 16'd13, 1'b0, 1'b0);
    cycle(1'b1, 16'd14, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    resetDut();
    idle(3);

    // Throughput: three full frames back to back.
    tq.delete();
    for (int k = 0; k < 12; k++) tq.push_back(16'($urandom));
    riseQ.delete();
    ti = 0;
    for (int k = 0; k < 24; k++) begin
      cycle(ti < 12, (ti < 12) ? tq[ti] : 16'h0, 1'b0, 1'b1);
      if (lastAcc) ti++;
    end
    checkVal("tput_pulses", riseQ.size(), 3);
    for (int i = 1; i < riseQ.size(); i++)
      checkVal("tput_gap", riseQ[i] - riseQ[i-1], 6);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [15:0] d;
      case ($urandom_range(0, 5))
        0:       d = 16'h0000;
        1:       d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
